// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the data-memory port arbiter: memory access size
//   encodings, arbiter FSM state encodings, default bus timeout and the
//   alignment helper used at accept time.
package mem_port_arbiter_pkg;

  localparam int CPU_WIDTH      = 32;
  localparam int MEM_SIZE_WIDTH = 3;

  localparam logic [MEM_SIZE_WIDTH-1:0] MEM_BYTE   = 3'd0;
  localparam logic [MEM_SIZE_WIDTH-1:0] MEM_HALF   = 3'd1;
  localparam logic [MEM_SIZE_WIDTH-1:0] MEM_WORD   = 3'd2;
  localparam logic [MEM_SIZE_WIDTH-1:0] MEM_BYTE_U = 3'd3;
  localparam logic [MEM_SIZE_WIDTH-1:0] MEM_HALF_U = 3'd4;

  localparam int ARB_STATE_WIDTH     = 3;
  localparam int ARB_TIMEOUT_DEFAULT = 255;

  typedef enum logic [ARB_STATE_WIDTH-1:0] {
    ARB_IDLE   = 3'd0,
    ARB_BUSY_I = 3'd1,
    ARB_BUSY_D = 3'd2,
    ARB_ERR_I  = 3'd3,
    ARB_ERR_D  = 3'd4
  } arb_state_e;

  // True when an access of the given size cannot be issued at this byte offset.
  function automatic logic misaligned(input logic [MEM_SIZE_WIDTH-1:0] size,
                                      input logic [1:0]                lo);
    logic r;
    r = 1'b0;
    case (size)
      MEM_HALF, MEM_HALF_U: r = lo[0];
      MEM_WORD:             r = (lo != 2'b00);
      default:              r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_timeout.sv
// mem_arb_timeout
//   Saturating bus-wait counter. Cleared when a request is accepted, counts
//   each cycle the arbiter waits on the memory without completion.
//   expired_o flags the cycle whose increment reaches LIMIT, so the owner can
//   abandon the access in that same cycle (LIMIT waiting cycles in total).
// Ports:
//   clk, rst   clock / synchronous active-high reset
//   clr_i      clear count (request accepted)
//   en_i       count this cycle (busy, no mem_ready)
//   expired_o  this cycle is the LIMIT-th waiting cycle
module mem_arb_timeout
  import mem_port_arbiter_pkg::*;
#(
  parameter int LIMIT = ARB_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                               cnt_d = '0;
    else if (en_i && (cnt_q != CW'(LIMIT)))  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = en_i && (cnt_q >= CW'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single data-memory port between instruction fetch (IF) and the
//   load/store unit (LSU). Requests are accepted only in IDLE, registered and
//   held on the bus until mem_ready; the owner gets a one-cycle registered
//   response pulse. Misaligned requests never reach the bus and return an
//   error; a bus that stays silent for TIMEOUT_CYCLES also returns an error.
// Ports:
//   clk, rst                        clock / synchronous active-high reset
//   if_req_* / if_addr              fetch request (always a word read)
//   if_resp_valid/if_rdata/if_err   fetch response pulse
//   d_req_* / d_addr/d_wdata/d_we/d_size   LSU request (d_we active-low)
//   d_resp_valid/d_rdata/d_err      LSU response pulse
//   mem_*                           memory bus (mem_we active-low)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = CPU_WIDTH,
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req_valid,
  output logic                      if_req_ready,
  input  logic [ADDR_WIDTH-1:0]     if_addr,
  output logic                      if_resp_valid,
  output logic [DATA_WIDTH-1:0]     if_rdata,
  output logic                      if_err,
  input  logic                      d_req_valid,
  output logic                      d_req_ready,
  input  logic [ADDR_WIDTH-1:0]     d_addr,
  input  logic [DATA_WIDTH-1:0]     d_wdata,
  input  logic                      d_we,
  input  logic [MEM_SIZE_WIDTH-1:0] d_size,
  output logic                      d_resp_valid,
  output logic [DATA_WIDTH-1:0]     d_rdata,
  output logic                      d_err,
  output logic                      mem_valid,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [MEM_SIZE_WIDTH-1:0] mem_size,
  input  logic                      mem_ready,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  arb_state_e                state_q;
  logic                      last_d_q;
  logic                      mem_valid_q, mem_we_q;
  logic [ADDR_WIDTH-1:0]     mem_addr_q;
  logic [DATA_WIDTH-1:0]     mem_wdata_q;
  logic [MEM_SIZE_WIDTH-1:0] mem_size_q;
  logic                      if_resp_valid_q, if_err_q;
  logic [DATA_WIDTH-1:0]     if_rdata_q;
  logic                      d_resp_valid_q, d_err_q;
  logic [DATA_WIDTH-1:0]     d_rdata_q;

  logic idle, busy, if_acc, d_acc, d_mis, if_mis, tmo_expired;

  assign idle = (state_q == ARB_IDLE);
  assign busy = (state_q == ARB_BUSY_I) || (state_q == ARB_BUSY_D);

  // LSU wins a tie unless it won the previous grant: dual streams alternate.
  assign if_req_ready = idle && (!d_req_valid || last_d_q);
  assign d_req_ready  = idle && (!if_req_valid || !last_d_q);

  assign if_acc = if_req_valid && if_req_ready;
  assign d_acc  = d_req_valid && d_req_ready;
  assign d_mis  = misaligned(d_size, d_addr[1:0]);
  assign if_mis = (if_addr[1:0] != 2'b00);

  mem_arb_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (if_acc || d_acc),
    .en_i      (busy && !mem_ready),
    .expired_o (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ARB_IDLE;
      last_d_q        <= 1'b0;
      mem_valid_q     <= 1'b0;
      mem_we_q        <= 1'b1;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_size_q      <= MEM_WORD;
      if_resp_valid_q <= 1'b0;
      if_err_q        <= 1'b0;
      if_rdata_q      <= '0;
      d_resp_valid_q  <= 1'b0;
      d_err_q         <= 1'b0;
      d_rdata_q       <= '0;
    end else begin
      // Responses are single-cycle pulses; rdata/err read as zero between them.
      if_resp_valid_q <= 1'b0;
      if_err_q        <= 1'b0;
      if_rdata_q      <= '0;
      d_resp_valid_q  <= 1'b0;
      d_err_q         <= 1'b0;
      d_rdata_q       <= '0;
      case (state_q)
        ARB_IDLE: begin
          if (d_acc) begin
            last_d_q    <= 1'b1;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            mem_size_q  <= d_size;
            if (d_mis) begin
              state_q <= ARB_ERR_D;
            end else begin
              state_q     <= ARB_BUSY_D;
              mem_valid_q <= 1'b1;
              mem_we_q    <= d_we;
            end
          end else if (if_acc) begin
            last_d_q   <= 1'b0;
            mem_addr_q <= if_addr;
            mem_size_q <= MEM_WORD;
            if (if_mis) begin
              state_q <= ARB_ERR_I;
            end else begin
              state_q     <= ARB_BUSY_I;
              mem_valid_q <= 1'b1;
              mem_we_q    <= 1'b1;
            end
          end
        end
        ARB_BUSY_I, ARB_BUSY_D: begin
          // mem_ready in the expiry cycle still counts as a normal completion.
          if (mem_ready || tmo_expired) begin
            state_q     <= ARB_IDLE;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b1;
            if (state_q == ARB_BUSY_I) begin
              if_resp_valid_q <= 1'b1;
              if_err_q        <= !mem_ready;
              if_rdata_q      <= mem_ready ? mem_rdata : '0;
            end else begin
              d_resp_valid_q <= 1'b1;
              d_err_q        <= !mem_ready;
              // Stores return zero data.
              d_rdata_q      <= (mem_ready && mem_we_q) ? mem_rdata : '0;
            end
          end
        end
        ARB_ERR_I: begin
          state_q         <= ARB_IDLE;
          if_resp_valid_q <= 1'b1;
          if_err_q        <= 1'b1;
        end
        ARB_ERR_D: begin
          state_q        <= ARB_IDLE;
          d_resp_valid_q <= 1'b1;
          d_err_q        <= 1'b1;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign mem_valid     = mem_valid_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_size      = mem_size_q;
  assign if_resp_valid = if_resp_valid_q;
  assign if_err        = if_err_q;
  assign if_rdata      = if_rdata_q;
  assign d_resp_valid  = d_resp_valid_q;
  assign d_err         = d_err_q;
  assign d_rdata       = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_valid = 1'b0, if_req_ready;
  logic [31:0] if_addr = '0;
  logic        if_resp_valid, if_err;
  logic [31:0] if_rdata;
  logic        d_req_valid = 1'b0, d_req_ready;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_we = 1'b1;
  logic [2:0]  d_size = MEM_WORD;
  logic        d_resp_valid, d_err;
  logic [31:0] d_rdata;
  logic        mem_valid, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_size;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_we(d_we), .d_size(d_size),
    .d_resp_valid(d_resp_valid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit          is_d;
    logic [31:0] addr, wdata;
    bit          we;
    logic [2:0]  size;
    int          delay;   // busy cycles before mem_ready; -1 = never
    logic [31:0] rd;
    bit          err;
    logic [31:0] exp_rd;
    int          lat;     // accept cycle -> response cycle
    bit          bus;     // request expected to appear on the memory bus
  } vec_t;

  typedef struct {
    bit          is_d, err, bus, we;
    logic [31:0] rdata, addr, wdata;
    logic [2:0]  size;
    int          lat, cyc;
  } exp_t;

  exp_t sb[$];
  exp_t pend_if, pend_d, wat_e, mon_e;
  bit   grant_log[$];
  vec_t tbl[12];
  int   n_chk = 0, n_pass = 0, cyc = 0, resp_cnt = 0, grant_cnt = 0;
  int   mem_delay = 0, busy_cnt = 0;
  logic [31:0] rd_val = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic vec_t mk(bit is_d, logic [31:0] addr, logic [31:0] wdata, bit we,
                              logic [2:0] size, int delay, logic [31:0] rd, bit err,
                              logic [31:0] exp_rd, int lat, bit bus);
    vec_t v;
    v.is_d = is_d; v.addr = addr; v.wdata = wdata; v.we = we; v.size = size;
    v.delay = delay; v.rd = rd; v.err = err; v.exp_rd = exp_rd; v.lat = lat; v.bus = bus;
    return v;
  endfunction

  function automatic exp_t to_exp(vec_t v);
    exp_t e;
    e.is_d = v.is_d; e.err = v.err; e.bus = v.bus; e.rdata = v.exp_rd;
    e.addr = v.addr; e.wdata = v.wdata; e.lat = v.lat; e.cyc = 0;
    e.we   = v.is_d ? v.we : 1'b1;
    e.size = v.is_d ? v.size : MEM_WORD;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Memory model: mem_ready after mem_delay busy cycles.
  always @(negedge clk) begin
    if (mem_valid) begin
      mem_ready = (mem_delay >= 0) && (busy_cnt == mem_delay);
      mem_rdata = mem_ready ? rd_val : 32'h0;
      busy_cnt  = mem_ready ? 0 : busy_cnt + 1;
    end else begin
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      busy_cnt  = 0;
    end
  end

  // Acceptance watcher: pushes the expected response when a handshake is seen.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (if_req_valid && d_req_valid)
        chk("never_both_ready", {31'b0, if_req_ready && d_req_ready}, 32'h0);
      if (d_req_valid && d_req_ready) begin
        wat_e = pend_d; wat_e.cyc = cyc + pend_d.lat;
        sb.push_back(wat_e); grant_log.push_back(1'b1); grant_cnt++;
      end else if (if_req_valid && if_req_ready) begin
        wat_e = pend_if; wat_e.cyc = cyc + pend_if.lat;
        sb.push_back(wat_e); grant_log.push_back(1'b0); grant_cnt++;
      end
    end
  end

  // Response / bus monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_resp_valid || d_resp_valid) begin
        chk("one_resp_per_cycle", {31'b0, if_resp_valid && d_resp_valid}, 32'h0);
        if (sb.size() == 0) fail("unexpected_resp");
        else begin
          mon_e = sb.pop_front();
          resp_cnt++;
          chk("resp_owner", {31'b0, d_resp_valid}, {31'b0, mon_e.is_d});
          chk("resp_err", {31'b0, mon_e.is_d ? d_err : if_err}, {31'b0, mon_e.err});
          chk("resp_rdata", mon_e.is_d ? d_rdata : if_rdata, mon_e.rdata);
          chk("resp_cycle", cyc, mon_e.cyc);
        end
      end
      if (mem_valid) begin
        if (sb.size() == 0 || !sb[0].bus) fail("mem_valid_unexpected");
        else begin
          chk("mem_addr", mem_addr, sb[0].addr);
          chk("mem_we", {31'b0, mem_we}, {31'b0, sb[0].we});
          chk("mem_size", {29'b0, mem_size}, {29'b0, sb[0].size});
          if (!sb[0].we) chk("mem_wdata", mem_wdata, sb[0].wdata);
        end
      end else begin
        chk("mem_we_idle", {31'b0, mem_we}, 32'h1);
      end
    end
  end

  task automatic issue(input vec_t v);
    int g0;
    bit ok;
    @(negedge clk);
    mem_delay = v.delay;
    rd_val    = v.rd;
    if (v.is_d) begin
      pend_d = to_exp(v);
      d_req_valid = 1'b1; d_addr = v.addr; d_wdata = v.wdata; d_we = v.we; d_size = v.size;
    end else begin
      pend_if = to_exp(v);
      if_req_valid = 1'b1; if_addr = v.addr;
    end
    g0 = grant_cnt; ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #2;
      if (grant_cnt != g0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) fail("accept_timeout");
    @(negedge clk);
    if_req_valid = 1'b0; d_req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 30 && sb.size() != 0; c++) @(negedge clk);
    if (sb.size() != 0) begin fail("resp_timeout"); sb.delete(); end
  endtask

  // Hold both requesters valid until n grants have been made.
  task automatic dual(input int n, output int g0);
    bit ok;
    pend_if = to_exp(mk(0, 32'h500, 32'h0, 1, MEM_WORD, 0, 32'h11, 0, 32'h11, 2, 1));
    pend_d  = to_exp(mk(1, 32'h600, 32'h0, 1, MEM_WORD, 0, 32'h11, 0, 32'h11, 2, 1));
    @(negedge clk);
    mem_delay = 0; rd_val = 32'h11;
    if_req_valid = 1'b1; if_addr = 32'h500;
    d_req_valid = 1'b1; d_addr = 32'h600; d_we = 1'b1; d_size = MEM_WORD;
    g0 = grant_cnt; ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      #2;
      if (grant_cnt >= g0 + n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) fail("dual_grant_timeout");
    @(negedge clk);
    if_req_valid = 1'b0; d_req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, r0;
    bit ord[4];
    ord[0] = 1'b1; ord[1] = 1'b0; ord[2] = 1'b1; ord[3] = 1'b0;

    //        is_d addr          wdata         we size        dly rd            err exp_rd        lat bus
    tbl[0]  = mk(0, 32'h100, 32'h0,        1, MEM_WORD,   2,  32'h00000013, 0, 32'h00000013, 4, 1);
    tbl[1]  = mk(1, 32'h200, 32'hDEADBEEF, 0, MEM_WORD,   0,  32'h12345678, 0, 32'h0,        2, 1);
    tbl[2]  = mk(1, 32'h201, 32'h0,        1, MEM_HALF,   0,  32'h0,        1, 32'h0,        2, 0);
    tbl[3]  = mk(1, 32'h204, 32'h0,        1, MEM_WORD,   1,  32'hCAFEF00D, 0, 32'hCAFEF00D, 3, 1);
    tbl[4]  = mk(1, 32'h202, 32'h0,        1, MEM_HALF_U, 0,  32'h0000BEEF, 0, 32'h0000BEEF, 2, 1);
    tbl[5]  = mk(1, 32'h203, 32'h0,        1, MEM_BYTE,   0,  32'hFFFFFF80, 0, 32'hFFFFFF80, 2, 1);
    tbl[6]  = mk(1, 32'h206, 32'h0,        1, MEM_WORD,   0,  32'h0,        1, 32'h0,        2, 0);
    tbl[7]  = mk(0, 32'h102, 32'h0,        1, MEM_WORD,   0,  32'h0,        1, 32'h0,        2, 0);
    tbl[8]  = mk(1, 32'h20A, 32'h0000AAAA, 0, MEM_HALF,   3,  32'h77777777, 0, 32'h0,        5, 1);
    tbl[9]  = mk(1, 32'h300, 32'h0,        1, MEM_WORD,   3,  32'h00000055, 0, 32'h00000055, 5, 1);
    tbl[10] = mk(0, 32'h104, 32'h0,        1, MEM_WORD,   0,  32'h00000093, 0, 32'h00000093, 2, 1);
    tbl[11] = mk(1, 32'h005, 32'h0,        1, MEM_BYTE_U, 0,  32'h000000AB, 0, 32'h000000AB, 2, 1);

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h1);
    chk("rst_mem_size", {29'b0, mem_size}, {29'b0, MEM_WORD});
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_if_resp", {30'b0, if_resp_valid, if_err}, 32'h0);
    chk("rst_d_resp", {30'b0, d_resp_valid, d_err}, 32'h0);
    chk("rst_rdata", if_rdata | d_rdata, 32'h0);
    rst = 1'b0;
    #2;
    chk("rst_if_ready", {31'b0, if_req_ready}, 32'h1);
    chk("rst_d_ready", {31'b0, d_req_ready}, 32'h1);

    // Dual requesters from reset: D, I, D, I.
    dual(4, g0);
    drain();
    for (int i = 0; i < 4; i++) begin
      if (grant_log.size() > g0 + i) chk("grant_order", {31'b0, grant_log[g0 + i]}, {31'b0, ord[i]});
      else fail("grant_order_missing");
    end

    // Table-driven single transactions.
    for (int i = 0; i < 12; i++) begin
      issue(tbl[i]);
      drain();
    end

    // Timeout: 4 silent busy cycles, then error; IDLE again in the response cycle.
    r0 = resp_cnt;
    issue(mk(1, 32'h400, 32'h0, 1, MEM_WORD, -1, 32'h0, 1, 32'h0, 1 + TO, 1));
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #2;
      if (resp_cnt != r0) break;
    end
    if (resp_cnt == r0) fail("timeout_resp_missing");
    chk("timeout_mem_valid_dropped", {31'b0, mem_valid}, 32'h0);
    chk("timeout_if_ready", {31'b0, if_req_ready}, 32'h1);
    chk("timeout_d_ready", {31'b0, d_req_ready}, 32'h1);
    drain();

    // Reset in BUSY_D: access abandoned, no response, tie then goes to D.
    issue(mk(1, 32'h700, 32'h0, 1, MEM_WORD, -1, 32'h0, 1, 32'h0, 1 + TO, 1));
    #3;
    chk("busy_before_rst", {31'b0, mem_valid}, 32'h1);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_mem_valid", {31'b0, mem_valid}, 32'h0);
    chk("midrst_mem_we", {31'b0, mem_we}, 32'h1);
    chk("midrst_d_resp", {31'b0, d_resp_valid}, 32'h0);
    rst = 1'b0;
    #2;
    chk("midrst_if_ready", {31'b0, if_req_ready}, 32'h1);
    repeat (6) @(negedge clk);
    dual(1, g0);
    drain();
    if (grant_log.size() > g0) chk("tie_after_rst", {31'b0, grant_log[g0]}, 32'h1);
    else fail("tie_after_rst_missing");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single data-memory port between instruction fetch (IF) and the load/store unit (LSU). The LSU side carries the `mem_valid_ctrl` / `mem_we_ctrl` / `mem_size` attributes produced by the decoder. The block arbitrates between the two requesters, registers the winning request, and holds it on the memory bus until `mem_ready`. It also returns a one-cycle response to the owner, with alignment checking and a bus timeout.

Parameters:
ADDR_WIDTH, 32, byte-address width.
DATA_WIDTH, `CPU_WIDTH (32), data width.
TIMEOUT_CYCLES, 255, number of BUSY cycles without `mem_ready` before an error response; must be ≥1.

Ports:
clk  in  1  single system clock; all state updates on its rising edge.
rst  in  1  reset, synchronous, active-high.
if_req_valid  in  1  IF fetch request (always a word read).
if_req_ready  out  1  IF request accepted when valid & ready.
if_addr  in  ADDR_WIDTH  fetch address.
if_resp_valid  out  1  one-cycle response pulse to IF.
if_rdata  out  DATA_WIDTH  fetched word.
if_err  out  1  qualifies if_resp_valid: misaligned or timeout.
d_req_valid  in  1  LSU request (driven by mem_valid_ctrl).
d_req_ready  out  1  LSU request accepted.
d_addr  in  ADDR_WIDTH  ALU-computed address.
d_wdata  in  DATA_WIDTH  store data.
d_we  in  1  active-low write enable, same sense as mem_we_ctrl (0 = store).
d_size  in  `MEM_SIZE_WIDTH  `MEM_BYTE/HALF/WORD/BYTE_U/HALF_U.
d_resp_valid  out  1  one-cycle response pulse to LSU.
d_rdata  out  DATA_WIDTH  load data.
d_err  out  1  qualifies d_resp_valid.
mem_valid  out  1  memory request valid.
mem_we  out  1  active-low write enable.
mem_addr  out  ADDR_WIDTH  memory address.
mem_wdata  out  DATA_WIDTH  memory write data.
mem_size  out  `MEM_SIZE_WIDTH  access size.
mem_ready  in  1  memory completes the access in the cycle it is sampled high with mem_valid.
mem_rdata  in  DATA_WIDTH  read data, already extended per mem_size.

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D, ERR_I, ERR_D. A one-bit `last_d` register records the previous grant.
- Readiness is asserted only in IDLE:
  - if_req_ready = IDLE & (!d_req_valid | last_d)
  - d_req_ready = IDLE & (!if_req_valid | !last_d)
  - The two readies are never both high while both valids are high.
- Arbitration: the LSU wins ties unless last_d=1, in which case IF wins. Continuous dual requests therefore alternate D, I, D, I.
- Accept (IDLE, valid & ready):
  - Latch addr, wdata, we and size (IF: we=1, size=`MEM_WORD).
  - Update last_d.
  - Go to BUSY_x, or to ERR_x if misaligned.
  - Misaligned means: HALF/HALF_U with addr[0]=1, WORD with addr[1:0]≠0, or any IF addr[1:0]≠0.
- BUSY_x:
  - mem_valid=1 with the latched attributes, held stable until mem_ready.
  - On mem_ready=1: capture mem_rdata, pulse x_resp_valid with err=0 in the next cycle, go to IDLE.
  - For stores, d_rdata=0.
  - Latency: accept at cycle N, mem_valid from N+1; mem_ready at N+k gives resp_valid at N+k+1. Next accept is possible at N+k+1.
- Timeout:
  - A counter clears on accept and increments each BUSY cycle with mem_ready=0.
  - When it reaches TIMEOUT_CYCLES: drop mem_valid, go to IDLE, pulse resp_valid with err=1 and rdata=0.
  - mem_ready arriving in that same cycle takes precedence (normal completion).
- ERR_x: lasts one cycle. No memory access is issued; the next cycle pulses resp_valid with err=1 and rdata=0, and the FSM returns to IDLE.
- Response outputs are registered. resp_valid is high for exactly one cycle per accepted request, and at most one response is pulsed per cycle.
- Reset (including mid-transaction):
  - State=IDLE, last_d=0, counter=0.
  - mem_valid=0, mem_we=1, mem_size=`MEM_WORD, mem_addr/mem_wdata=0.
  - All resp_valid, err and rdata = 0.
  - An in-flight access is abandoned with no response.
- Outside BUSY: mem_valid=0 and mem_we=1. Address, data and size hold their last values.

Decomposition:
- defines.v (shared): ARB_STATE_WIDTH; the encodings ARB_IDLE/ARB_BUSY_I/ARB_BUSY_D/ARB_ERR_I/ARB_ERR_D; ARB_TIMEOUT_DEFAULT. The existing MEM_SIZE macros are reused.
- One sub-module, `mem_arb_timeout`: a saturating counter with clear/enable inputs and an expired output, width $clog2(TIMEOUT_CYCLES+1).

Test Plan:
1. IF-only fetch, addr 0x100, mem_ready two cycles after mem_valid, rdata 0x00000013 -> if_resp_valid one pulse with rdata 0x13 and err=0; mem_we=1 and mem_size=WORD throughout.
2. Both requesters hold valid for 4 grants from reset (last_d=0) -> grant order D, I, D, I; never both ready.
3. LSU sw 0xDEADBEEF to 0x200, d_we=0, mem_ready immediate -> mem_we=0 and mem_wdata=0xDEADBEEF for 1 cycle; d_resp_valid next cycle with d_rdata=0.
4. LSU lh at 0x201 -> mem_valid never rises; d_resp_valid with d_err=1 two cycles after accept.
5. TIMEOUT_CYCLES=4, mem_ready held 0 -> mem_valid drops after 4 BUSY cycles; resp with err=1 and rdata=0; a new accept is possible the next cycle.
6. rst asserted in BUSY_D -> next cycle IDLE, mem_valid=0, no d_resp_valid; after rst, the first tie is granted to D.
